// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and load sanitiser for the BCD up/down counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  // Non-decimal nibbles collapse to zero so a digit never leaves 0..9.
  function automatic bcd_digit_t bcd_sanitize(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_ZERO : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with up/down step and carry/borrow out.
// Load port and load mux exist only when BCD_LOAD_EN is defined.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       step_in,
  input  logic       up,
  input  logic       clear,
`ifdef BCD_LOAD_EN
  input  logic       load,
  input  bcd_digit_t load_digit,
`endif
  output bcd_digit_t digit,
  output logic       step_out
);

  bcd_digit_t digit_next;

  always_comb begin
    digit_next = digit;
    if (step_in) begin
      if (up) digit_next = (digit == BCD_MAX)  ? BCD_ZERO : digit + 4'd1;
      else    digit_next = (digit == BCD_ZERO) ? BCD_MAX  : digit - 4'd1;
    end
  end

  assign step_out = step_in && (up ? (digit == BCD_MAX) : (digit == BCD_ZERO));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     digit <= BCD_ZERO;
    else if (clear) digit <= BCD_ZERO;
`ifdef BCD_LOAD_EN
    else if (load)  digit <= bcd_sanitize(load_digit);
`endif
    else            digit <= digit_next;
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with prescaler, clear and roll-over pulse.
// Define BCD_LOAD_EN to add the load/load_val parallel-load ports.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  clear,
`ifdef BCD_LOAD_EN
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
`endif
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  tick,
  output logic                  wrap
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             carry [0:DIGITS];

  assign tick     = enable && (pre == PRE_LAST);
  assign carry[0] = tick;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)      pre <= '0;
    else if (clear)  pre <= '0;
    else if (enable) pre <= (pre == PRE_LAST) ? '0 : pre + PRE_W'(1);
  end

  // Carry/borrow ripples combinationally from digit 0 upward.
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit_cell u_cell (
      .clock      (clock),
      .reset      (reset),
      .step_in    (carry[k]),
      .up         (up),
      .clear      (clear),
`ifdef BCD_LOAD_EN
      .load       (load),
      .load_digit (load_val[4*k +: 4]),
`endif
      .digit      (bcd[4*k +: 4]),
      .step_out   (carry[k+1])
    );
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     wrap <= 1'b0;
    else if (clear) wrap <= 1'b0;
`ifdef BCD_LOAD_EN
    else if (load)  wrap <= 1'b0;
`endif
    else            wrap <= carry[DIGITS];
  end

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-digit BCD counter with a built-in prescaler, up/down direction, synchronous clear, optional parallel load and a wrap pulse. It replaces the fixed 3-digit, up-only, 1 MHz-divider counter feeding the seven-segment decoders on the DE1 lab tops. Its digit outputs drive one `display_0_9` decoder per digit unchanged.

## Interface
- `DIGITS`, default 3: number of BCD digits; legal range 1..8.
- `TICK_DIV`, default 1000000: clock cycles per count step; legal range ≥1.
- `clock`  in  1  system clock (CLOCK_50 at top).
- `reset`  in  1  asynchronous, active-low reset (KEY[0] at top).
- `enable`  in  1  1 = prescaler runs and counting is allowed; 0 = prescaler and digits hold.
- `up`  in  1  direction: 1 = count up, 0 = count down.
- `clear`  in  1  synchronous clear of digits and prescaler.
- `load`  in  1  synchronous parallel load strobe. Present only with `BCD_LOAD_EN`.
- `load_val`  in  4*DIGITS  value to load; digit 0 is bits [3:0]. Present only with `BCD_LOAD_EN`.
- `bcd`  out  4*DIGITS  current count; digit k is bits [4k+3:4k].
- `tick`  out  1  combinational step strobe.
- `wrap`  out  1  registered one-cycle pulse on roll-over.

## Operation
- Prescaler `pre` has width $clog2(TICK_DIV), minimum 1. It counts 0..TICK_DIV-1 while `enable`=1, wraps to 0, and holds while `enable`=0.
- `tick` = `enable` && (`pre` == TICK_DIV-1). With TICK_DIV=1, `tick` = `enable`.
- On a tick with `up`=1: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit. All-9s goes to all-0s and asserts `wrap`.
- On a tick with `up`=0: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit. All-0s goes to all-9s and asserts `wrap`.
- Priority, highest first: `reset`, `clear`, `load`, tick step.
  - `clear` zeroes `bcd` and `pre` and suppresses any step and `wrap` in that cycle.
  - `load` writes `load_val` to `bcd`, does not touch `pre`, and suppresses the step and `wrap`.
- Any `load_val` nibble >9 loads as 0 in that digit. Other digits load normally.
- `up` is sampled only on tick cycles. A direction change between ticks has no other effect.
- Reset values: `bcd`=0, `pre`=0, `wrap`=0. `tick`=0 follows from `pre`=0, except TICK_DIV=1 with `enable`=1.
- Asserting `reset` mid-count clears immediately, with no clock needed. Counting resumes from 0 at the first enabled edge after release.
- Digits always hold valid BCD values 0..9.

## Timing
- Step latency: `bcd` shows the new value in the cycle after the edge on which `tick`=1, i.e. one clock.
- `wrap` is high for exactly the one cycle in which `bcd` first shows the rolled-over value.
- With `enable` held high, the step period is exactly TICK_DIV clocks and the first step comes TICK_DIV clocks after reset release.
- `load`/`clear` take effect on the next edge, with `bcd` updated one cycle later.
- No combinational path from `up` or `load_val` to any output. `tick` depends combinationally only on `enable`.

## Configuration
- `BCD_LOAD_EN`
  - Defined: `load` and `load_val` ports exist and load behaves as in Operation.
  - Undefined: both ports are absent, no load mux is synthesised, and priority reduces to `reset`, `clear`, step.

## Structure
- Package `bcd_pkg` holds:
  - `typedef logic [3:0] bcd_digit_t`.
  - Constants `BCD_MAX`=4'd9 and `BCD_ZERO`=4'd0.
  - A function `bcd_sanitize` that maps nibbles >9 to 0.
- Sub-module `bcd_digit_cell`, one instance per digit in a generate loop:
  - Inputs: step-in, `up`, clear, load, load digit.
  - Outputs: digit, and carry/borrow-out = step-in && (`up` ? digit==9 : digit==0).
  - The carry chain ripples combinationally from digit 0. `wrap` is the registered carry-out of the top digit.

## Test plan
Run with DIGITS=3 and TICK_DIV=4 unless stated.
1. Release `reset`, `enable`=1, `up`=1 → `tick` every 4th clock. `bcd` reads 001 after 4 clocks and 010 after 40.
2. Load 998, count up 2 steps → 999 then 000, with `wrap` high for exactly one cycle on 000.
3. From 000 with `up`=0 → 999 with a `wrap` pulse, then 998. Load 100 and step down → 099.
4. `enable`=0 for 10 clocks mid-count → `bcd` and `pre` frozen. On re-enable, the next tick lands after the remaining prescaler cycles.
5. `clear` and `load`=1 with `load_val`=0x5A3 on a tick cycle → `bcd`=000 and no `wrap`. Next, `load` alone with 0x5A3 → `bcd`=503.
6. Assert `reset` between clock edges at 457 → `bcd`=000 immediately. With TICK_DIV=1, `bcd` steps every enabled clock.
